// File: rtl/dmem_resp.sv
// dmem_resp
// ---------
// Data-memory responder for the execute/memory-stage load/store interface.
// It accepts one request at a time, waits LATENCY cycles, and then performs
// one sized, aligned, little-endian access on an internal word array. The
// extended load data (or an error) is returned through a valid/ready
// response channel.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. A producer holding valid keeps its
// payload stable until that edge. Here resp_* are registered, so they stay
// stable for the whole RESP state. req_ready depends only on state, never
// on req_valid.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   req_valid   request present
//   req_ready   responder can accept a request (high only when IDLE)
//   req_write   1 = store, 0 = load
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   req_funct3  RV32I load/store funct3
//   req_rd      destination register, echoed on resp_rd
//   resp_valid  response present (high only in RESP)
//   resp_ready  consumer accepts the response
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_rd     echoed req_rd
//   resp_err    misaligned, illegal funct3 or out-of-range request
//   busy        state != IDLE

module dmem_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request.
    logic [3:0]  cnt;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_rd;

    // Registered response.
    logic [31:0] rdata_q;
    logic [4:0]  rd_q;
    logic        err_q;

    // Word array; deliberately has no reset.
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        do_access;
    logic        mem_we;
    logic        funct3_ok;
    logic        align_ok;
    logic        range_ok;
    logic        legal;
    logic [IDX_W-1:0] word_idx;
    logic [31:0] rd_word;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic [3:0]  store_mask;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                // No accept on the handshake edge: req_ready is low here
                // and only rises once the state is back in IDLE.
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = req_valid && (state == IDLE);
    assign do_access = (state == ACCESS) && (cnt == 4'd0);

    // ------------------------------------------------------------------
    // Legality of the latched request
    // ------------------------------------------------------------------
    always_comb begin
        funct3_ok = 1'b0;
        if (lat_write) begin
            funct3_ok = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                        (lat_funct3 == 3'b010);
        end else begin
            funct3_ok = (lat_funct3 == 3'b000) || (lat_funct3 == 3'b001) ||
                        (lat_funct3 == 3'b010) || (lat_funct3 == 3'b100) ||
                        (lat_funct3 == 3'b101);
        end
    end

    // funct3[1:0] encodes the access size for every legal code.
    always_comb begin
        align_ok = 1'b1;
        case (lat_funct3[1:0])
            2'b01:   align_ok = (lat_addr[0] == 1'b0);
            2'b10:   align_ok = (lat_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    // Compare the full word index, so high address bits cannot alias
    // into the array.
    assign range_ok = ({2'b00, lat_addr[31:2]} < 32'(DEPTH_WORDS));
    assign legal    = funct3_ok && align_ok && range_ok;
    assign word_idx = lat_addr[IDX_W+1:2];

    // ------------------------------------------------------------------
    // Load path: lane select and extension
    // ------------------------------------------------------------------
    assign rd_word = mem[word_idx];

    always_comb begin
        sel_byte = rd_word[7:0];
        case (lat_addr[1:0])
            2'b00:   sel_byte = rd_word[7:0];
            2'b01:   sel_byte = rd_word[15:8];
            2'b10:   sel_byte = rd_word[23:16];
            default: sel_byte = rd_word[31:24];
        endcase
    end

    assign sel_half = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = 32'd0;
        case (lat_funct3)
            3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
            3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, sel_byte};
            3'b101:  load_data = {16'd0, sel_half};
            default: load_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store path: replicate the data across lanes, enable only the
    // addressed bytes so unselected bytes are preserved.
    // ------------------------------------------------------------------
    always_comb begin
        store_data = lat_wdata;
        store_mask = 4'b0000;
        case (lat_funct3[1:0])
            2'b00: begin
                store_data = {4{lat_wdata[7:0]}};
                store_mask = 4'b0001 << lat_addr[1:0];
            end
            2'b01: begin
                store_data = {2{lat_wdata[15:0]}};
                store_mask = lat_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                store_data = lat_wdata;
                store_mask = 4'b1111;
            end
            default: begin
                store_data = lat_wdata;
                store_mask = 4'b0000;
            end
        endcase
    end

    // A reset during ACCESS forces IDLE asynchronously, so a pending
    // store can never reach this write port.
    assign mem_we = do_access && lat_write && legal;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (store_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            lat_rd     <= 5'd0;
            rdata_q    <= 32'd0;
            rd_q       <= 5'd0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt        <= 4'(LATENCY);
                lat_write  <= req_write;
                lat_addr   <= req_addr;
                lat_wdata  <= req_wdata;
                lat_funct3 <= req_funct3;
                lat_rd     <= req_rd;
            end
            if ((state == ACCESS) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (do_access) begin
                rdata_q <= (legal && !lat_write) ? load_data : 32'd0;
                err_q   <= !legal;
                rd_q    <= lat_rd;
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_rd    = rd_q;
    assign resp_err   = err_q;

endmodule
